// File: rtl/divider_ctrl_if.sv
// divider_ctrl_if: issue handshake and datapath control bundle for the
// Goldschmidt divider sequencer.
// Optional macro DIVIDER_CTRL_STALL_EN adds the stall request line.
interface divider_ctrl_if;
  logic       start;
`ifdef DIVIDER_CTRL_STALL_EN
  logic       stall;
`endif
  logic       busy;
  logic       done;
  logic [3:0] iter;
  logic       kSave;
  logic       nSave;
  logic       dSave;
  logic       kNextSel;
  logic [1:0] muxSelB;

  // Issuing side / environment: requests work, observes controls.
  modport master (
    output start,
`ifdef DIVIDER_CTRL_STALL_EN
    output stall,
`endif
    input  busy, done, iter, kSave, nSave, dSave, kNextSel, muxSelB
  );

  // Sequencer side.
  modport slave (
    input  start,
`ifdef DIVIDER_CTRL_STALL_EN
    input  stall,
`endif
    output busy, done, iter, kSave, nSave, dSave, kNextSel, muxSelB
  );
endinterface

// File: rtl/divider_ctrl.sv
// divider_ctrl: Moore sequencer for the shared-multiplier Goldschmidt
// divider datapath. Each iteration multiplies N then D by the same K,
// followed by one flush cycle into the quotient register and a done pulse.
// Optional macro DIVIDER_CTRL_STALL_EN: stall input freezes the sequence
// and masks the register enables and done.
module divider_ctrl #(
  parameter int unsigned ITERS = 3
) (
  input  logic           clk,
  input  logic           reset,
  divider_ctrl_if.slave  bus
);

  if (ITERS == 0 || ITERS > 15) begin : g_iters_check
    $error("divider_ctrl: ITERS must be in 1..15");
  end

  localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_N,
    S_MUL_D,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] iter_q, iter_nxt;
  logic       hold;

`ifdef DIVIDER_CTRL_STALL_EN
  assign hold = bus.stall;
`else
  assign hold = 1'b0;
`endif

  // State and iteration counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      iter_q <= '0;
    end else begin
      state  <= state_nxt;
      iter_q <= iter_nxt;
    end
  end

  // Next-state sequencing; a stall freezes both state and iteration.
  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_q;
    if (!hold) begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state_nxt = S_MUL_N;
            iter_nxt  = '0;
          end
        end
        S_MUL_N: state_nxt = S_MUL_D;
        S_MUL_D: begin
          if (iter_q < LAST_ITER) begin
            state_nxt = S_MUL_N;
            iter_nxt  = iter_q + 4'd1;
          end else begin
            state_nxt = S_FLUSH;
            iter_nxt  = '0;
          end
        end
        S_FLUSH: state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: begin
          state_nxt = S_IDLE;
          iter_nxt  = '0;
        end
      endcase
    end
  end

  // Moore output decode; stall masks only the enables and done, so the
  // multiplier operand selection stays stable through a stall.
  always_comb begin
    bus.busy     = (state != S_IDLE);
    bus.done     = 1'b0;
    bus.iter     = iter_q;
    bus.kSave    = 1'b0;
    bus.nSave    = 1'b0;
    bus.dSave    = 1'b0;
    bus.kNextSel = 1'b0;
    bus.muxSelB  = 2'b00;
    unique case (state)
      S_IDLE: ;
      S_MUL_N: begin
        bus.nSave = 1'b1;
        if (iter_q == '0) begin
          bus.kNextSel = 1'b1;
          bus.muxSelB  = 2'b00;
        end else begin
          bus.muxSelB  = 2'b10;
        end
      end
      S_MUL_D: begin
        bus.dSave = 1'b1;
        bus.kSave = 1'b1;
        if (iter_q == '0) begin
          bus.kNextSel = 1'b1;
          bus.muxSelB  = 2'b01;
        end else begin
          bus.muxSelB  = 2'b11;
        end
      end
      S_FLUSH: begin
        bus.nSave   = 1'b1;
        bus.muxSelB = 2'b10;
      end
      S_DONE: bus.done = 1'b1;
      default: ;
    endcase
    if (hold) begin
      bus.kSave = 1'b0;
      bus.nSave = 1'b0;
      bus.dSave = 1'b0;
      bus.done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// tb_divider_ctrl: self-checking bench for divider_ctrl. A position-in-
// operation model predicts every output each cycle; directed runs pin the
// model with literal sequences; a random phase mixes start, stall and reset.
// Optional macro DIVIDER_CTRL_STALL_EN enables the stall stimulus.
module tb_divider_ctrl;
  localparam int unsigned ITERS = 3;
  localparam int FLUSH_POS = 2 * ITERS + 1;
  localparam int DONE_POS  = 2 * ITERS + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pos = 0;          // 0 idle, 1..2*ITERS iterations, then flush, done
  logic stall_s;

  divider_ctrl_if bus ();

  divider_ctrl #(.ITERS(ITERS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef DIVIDER_CTRL_STALL_EN
  assign stall_s = bus.stall;
`else
  assign stall_s = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: progress through the fixed schedule of one operation.
  always @(posedge clk or negedge reset) begin
    if (!reset)                 pos <= 0;
    else if (stall_s)           pos <= pos;
    else if (pos == 0)          pos <= bus.start ? 1 : 0;
    else if (pos == DONE_POS)   pos <= 0;
    else                        pos <= pos + 1;
  end

  // Per-cycle comparison against the schedule-derived expectations.
  always @(negedge clk) begin : compare
    int   it;
    logic in_iter, phase_d;
    logic e_done, e_n, e_d, e_ksel;
    logic [1:0] e_mux;
    in_iter = (pos >= 1) && (pos <= 2 * ITERS);
    it      = in_iter ? (pos - 1) / 2 : 0;
    phase_d = in_iter && (((pos - 1) % 2) == 1);
    e_done  = (pos == DONE_POS) && !stall_s;
    e_n     = ((in_iter && !phase_d) || pos == FLUSH_POS) && !stall_s;
    e_d     = in_iter && phase_d && !stall_s;
    e_ksel  = in_iter && (it == 0);
    e_mux   = in_iter ? (2'((it > 0) ? 2 : 0) + 2'(phase_d)) : ((pos == FLUSH_POS) ? 2'b10 : 2'b00);
    chk("busy",     8'(bus.busy),     8'(pos != 0));
    chk("done",     8'(bus.done),     8'(e_done));
    chk("iter",     8'(bus.iter),     8'(it));
    chk("nSave",    8'(bus.nSave),    8'(e_n));
    chk("dSave",    8'(bus.dSave),    8'(e_d));
    chk("kSave",    8'(bus.kSave),    8'(e_d));
    chk("kNextSel", 8'(bus.kNextSel), 8'(e_ksel));
    chk("muxSelB",  8'(bus.muxSelB),  8'(e_mux));
  end

  logic [1:0] rec_mux  [12];
  logic       rec_ksel [12];
  logic       rec_n    [12];
  logic       rec_d    [12];
  logic [3:0] rec_it   [12];
  logic       rec_busy [12];
  int         done_cyc;

  // Wait (at a negedge) until the DUT is idle, bounded.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({name, "_idle_timeout"}, 8'(bus.busy), 8'd0);
  endtask

  // Accept one request, then watch cycles 1..10; start re-pulsed in cycles a, b.
  task automatic run_one(input int a, input int b);
    wait_idle("run_one");
    bus.start = 1'b1;
    @(posedge clk);
    done_cyc = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rec_mux[k]  = bus.muxSelB;
      rec_ksel[k] = bus.kNextSel;
      rec_n[k]    = bus.nSave;
      rec_d[k]    = bus.dSave;
      rec_it[k]   = bus.iter;
      rec_busy[k] = bus.busy;
      if (bus.done === 1'b1 && done_cyc == 0) done_cyc = k;
      bus.start = (k == a) || (k == b);
    end
    bus.start = 1'b0;
  endtask

  logic [1:0] exp_mux  [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00};
  logic       exp_ksel [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       exp_n    [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       exp_d    [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] exp_it   [8] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0, 4'd0};

  initial begin
    int dcount, first_done, second_done, idle_between;
    bus.start = 1'b0;
`ifdef DIVIDER_CTRL_STALL_EN
    bus.stall = 1'b0;
`endif
    // Reset state.
    @(negedge clk);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_mux",  8'(bus.muxSelB), 8'd0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Single request: literal schedule.
    run_one(0, 0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("seq_mux%0d", k),  8'(rec_mux[k]),  8'(exp_mux[k-1]));
      chk($sformatf("seq_ksel%0d", k), 8'(rec_ksel[k]), 8'(exp_ksel[k-1]));
      chk($sformatf("seq_n%0d", k),    8'(rec_n[k]),    8'(exp_n[k-1]));
      chk($sformatf("seq_d%0d", k),    8'(rec_d[k]),    8'(exp_d[k-1]));
      chk($sformatf("seq_it%0d", k),   8'(rec_it[k]),   8'(exp_it[k-1]));
      chk($sformatf("seq_busy%0d", k), 8'(rec_busy[k]), 8'd1);
    end
    chk("seq_done_cycle", 8'(done_cyc), 8'd8);
    chk("seq_idle_after", 8'(rec_busy[9]), 8'd0);

    // Starts in MUL_D of iter 1 (cycle 4) and in DONE (cycle 8) are ignored.
    run_one(4, 8);
    chk("ign_done_cycle", 8'(done_cyc), 8'd8);
    chk("ign_mux4", 8'(rec_mux[4]), 8'b11);
    chk("ign_idle9", 8'(rec_busy[9]), 8'd0);
    chk("ign_idle10", 8'(rec_busy[10]), 8'd0);

    // Start held high for 20 cycles: back-to-back, one idle cycle between.
    wait_idle("b2b");
    bus.start = 1'b1;
    dcount = 0; first_done = 0; second_done = 0; idle_between = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dcount++;
        if (dcount == 1) first_done = k;
        if (dcount == 2) second_done = k;
      end
      if (dcount == 1 && bus.busy === 1'b0) idle_between++;
    end
    bus.start = 1'b0;
    chk("b2b_count", 8'(dcount), 8'd2);
    chk("b2b_spacing", 8'(second_done - first_done), 8'd9);
    chk("b2b_idle", 8'(idle_between), 8'd1);

    // Asynchronous reset in MUL_N of iter 2 (cycle 5).
    wait_idle("rst");
    bus.start = 1'b1;
    @(posedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy",  8'(bus.busy),     8'd0);
    chk("arst_nsave", 8'(bus.nSave),    8'd0);
    chk("arst_mux",   8'(bus.muxSelB),  8'd0);
    chk("arst_iter",  8'(bus.iter),     8'd0);
    chk("arst_ksel",  8'(bus.kNextSel), 8'd0);
    dcount = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcount++;
    end
    chk("arst_no_done", 8'(dcount), 8'd0);
    reset = 1'b1;
    run_one(0, 0);
    chk("arst_rerun_done", 8'(done_cyc), 8'd8);

`ifdef DIVIDER_CTRL_STALL_EN
    // Stall for cycles 2..4 (MUL_D of iter 0): done moves to cycle 11.
    wait_idle("stall");
    bus.start = 1'b1;
    done_cyc = 0;
    dcount = 0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.stall = (k >= 2) && (k <= 4);
      @(negedge clk);
      if (bus.done === 1'b1 && done_cyc == 0) done_cyc = k;
      if (bus.dSave === 1'b1) dcount++;
      if (k == 4) chk("stall_mux4", 8'(bus.muxSelB), 8'b01);
      if (k == 4) chk("stall_ksel4", 8'(bus.kNextSel), 8'd1);
    end
    bus.stall = 1'b0;
    chk("stall_done_cycle", 8'(done_cyc), 8'd11);
    chk("stall_dsave_count", 8'(dcount), 8'd3);
`endif

    // Random phase: start, stall and occasional asynchronous reset.
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      bus.start = ($urandom_range(0, 3) == 0);
`ifdef DIVIDER_CTRL_STALL_EN
      bus.stall = ($urandom_range(0, 5) == 0);
`endif
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end
    end
    bus.start = 1'b0;
`ifdef DIVIDER_CTRL_STALL_EN
    bus.stall = 1'b0;
`endif
    wait_idle("final");
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider_ctrl.md
Name: divider_ctrl

Overview:
- Moore FSM that sequences the shared-multiplier Goldschmidt divider datapath.
- Drives the datapath's kSave, nSave, dSave, kNextSel and muxSelB controls for a programmable number of refinement iterations.
- Emits one extra flush cycle so the datapath's quotient register captures the final N estimate.
- Sits between the issuing unit (start/done handshake) and the divider datapath.

Parameters:
ITERS, 3, number of Goldschmidt iterations; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request a divide; sampled only in IDLE.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; quotient/remainder valid this cycle.
iter  output  4  current iteration index, 0..ITERS-1; 0 outside iterations.
kSave  output  1  load enable for datapath K-next register.
nSave  output  1  load enable for datapath N-next and quotient registers.
dSave  output  1  load enable for datapath D-next register.
kNextSel  output  1  1 selects table approximation IA; 0 selects stored K-next.
muxSelB  output  2  multiplier right operand: 00 N, 01 D, 10 N-next, 11 D-next.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset=0:
  - state=IDLE, iter=0
  - busy, done, kSave, nSave, dSave, kNextSel=0
  - muxSelB=00
- Reset asserted mid-operation aborts immediately. No done is issued. Datapath register contents are don't-care.
- All outputs decode from state and iter only (Moore); no combinational path from start.
- States and outputs:
  - IDLE: all enables 0. start=1 at an edge → MUL_N, iter=0.
  - MUL_N: nSave=1. iter=0: kNextSel=1, muxSelB=00. iter>0: kNextSel=0, muxSelB=10. Next state → MUL_D.
  - MUL_D: dSave=1, kSave=1. iter=0: kNextSel=1, muxSelB=01. iter>0: kNextSel=0, muxSelB=11. Next state → MUL_N with iter+1 if iter<ITERS-1, else → FLUSH.
  - FLUSH: nSave=1, kNextSel=0, muxSelB=10. The quotient register captures the final N estimate. N-next is overwritten and is don't-care afterwards. Next state → DONE.
  - DONE: done=1, busy=1, all enables 0. Next state → IDLE unconditionally.
- Operand order per iteration is N first, then D. K-next is updated with D, so both products of one iteration use the same K.
- Latency:
  - Start accepted at edge t0; done is high in cycle t0+2*ITERS+2.
  - ITERS=3: done in the 8th cycle after acceptance.
  - Minimum issue interval is 2*ITERS+3 cycles.
- start while busy is ignored and not queued, including start in the DONE cycle.
- start held high continuously: a new operation is accepted on the first edge in IDLE after DONE. Result is back-to-back ops with one IDLE cycle between them.
- iter width is fixed at 4. ITERS outside 1..15 is illegal; the implementation asserts this at elaboration.

Optional Feature:
- Macro: DIVIDER_CTRL_STALL_EN.
- Defined:
  - Adds input port stall (1 bit, after start).
  - While stall=1: state and iter hold, and kSave, nSave, dSave, done are forced 0. kNextSel and muxSelB hold their state-decoded values.
  - stall=1 in IDLE blocks acceptance of start.
  - stall=1 in DONE holds done low and delays the pulse until the first non-stalled cycle.
- Undefined: no stall port. Behaviour exactly as above.

Test Plan:
- ITERS=3, reset released, start pulsed once → muxSelB sequence 00,01,10,11,10,11,10. kNextSel 1,1,0,0,0,0,0. nSave pattern 1,0,1,0,1,0,1. dSave=kSave pattern 0,1,0,1,0,1,0. iter 0,0,1,1,2,2,0. done=1 in the 8th cycle, then busy=0.
- Datapath in loop, N=0x3000 (0.75), D=0x6000 (1.5, fixed-point per datapath format), table entries loaded → quotient within 1 ulp of 0x2000 (0.5) in the done cycle.
- start held high across 20 cycles → exactly two done pulses, 9 cycles apart. Exactly one IDLE cycle (busy=0) between operations.
- start pulsed in MUL_D of iter 1 and again in the DONE cycle → neither is accepted. Sequence and done timing are identical to a single request.
- reset driven low in MUL_N of iter 2 → outputs reach reset values without waiting for a clock edge. No done pulse. After release, a new start runs a full 8-cycle operation.
- With DIVIDER_CTRL_STALL_EN, stall=1 for 3 cycles starting in MUL_D of iter 0 → enables 0 and state frozen during the stall. done is delayed to cycle 11. Output sequence otherwise unchanged.
